// File: rtl/gpio_rf_pkg.sv
// rtl/gpio_rf_pkg.sv - shared constants, field positions and FSM encoding for the GPIO register responder
package gpio_rf_pkg;

  // Command codes carried in the top byte of the command word
  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_SOFT_RST = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR = 8'h02;
  localparam logic [7:0] CMD_WR_LO    = 8'h03;
  localparam logic [7:0] CMD_WR_HI    = 8'h04;
  localparam logic [7:0] CMD_RD_LO    = 8'h05;
  localparam logic [7:0] CMD_RD_HI    = 8'h06;
  localparam logic [7:0] CMD_VERSION  = 8'h07;

  // Command word (processor -> fabric) field positions
  localparam int GPO_CMD_LSB = 24;
  localparam int GPO_REQ_BIT = 23;
  localparam int GPO_PAY_LSB = 0;

  // Response word (fabric -> processor) field positions
  localparam int GPI_CMD_LSB   = 24;
  localparam int GPI_ACK_BIT   = 23;
  localparam int GPI_ERR_BIT   = 22;
  localparam int GPI_RDATA_LSB = 0;

  localparam logic [15:0] DEFAULT_VERSION = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Assemble a response word; unused bits [21:16] are always zero
  function automatic logic [31:0] pack_gpi(input logic [7:0] cmd, input logic ack,
                                           input logic err, input logic [15:0] rdata);
    logic [31:0] w;
    w = '0;
    w[GPI_CMD_LSB +: 8]    = cmd;
    w[GPI_ACK_BIT]         = ack;
    w[GPI_ERR_BIT]         = err;
    w[GPI_RDATA_LSB +: 16] = rdata;
    return w;
  endfunction

endpackage

// File: rtl/gpio_rf_bank.sv
// rtl/gpio_rf_bank.sv - write-register storage, address range checks and read mux
module gpio_rf_bank
  import gpio_rf_pkg::*;
#(
  parameter int N_WREG  = 8,
  parameter int N_RREG  = 8,
  parameter int NB_ADDR = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  we,
  input  logic [NB_ADDR-1:0]    addr,
  input  logic [31:0]           wdata,
  input  logic [N_RREG*32-1:0]  rregs,
  output logic [N_WREG*32-1:0]  wregs,
  output logic                  wr_ok,
  output logic                  rd_ok,
  output logic [31:0]           rdata
);

  localparam int NB_WIDX = (N_WREG > 1) ? $clog2(N_WREG) : 1;
  localparam int NB_RIDX = (N_RREG > 1) ? $clog2(N_RREG) : 1;

  logic [31:0]        mem [N_WREG];
  logic [31:0]        rr  [N_RREG];
  logic [NB_WIDX-1:0] widx;
  logic [NB_RIDX-1:0] ridx;

  // Write registers occupy the bottom of the map, read-only registers follow
  assign wr_ok = int'(addr) < N_WREG;
  assign rd_ok = int'(addr) < (N_WREG + N_RREG);
  assign widx  = NB_WIDX'(addr);
  assign ridx  = NB_RIDX'(addr - NB_ADDR'(N_WREG));

  for (genvar k = 0; k < N_WREG; k++) begin : g_wflat
    assign wregs[32*k +: 32] = mem[k];
  end

  for (genvar k = 0; k < N_RREG; k++) begin : g_rsplit
    assign rr[k] = rregs[32*k +: 32];
  end

  // Register storage: hard reset and soft clear both zero the bank; writes only land in range
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      for (int k = 0; k < N_WREG; k++) mem[k] <= '0;
    end else if (we && wr_ok) begin
      mem[widx] <= wdata;
    end
  end

  // Read mux: write register, read-only register, or zero when out of range
  always_comb begin
    rdata = '0;
    if (wr_ok) begin
      rdata = mem[widx];
    end else if (rd_ok) begin
      rdata = rr[ridx];
    end
  end

endmodule

// File: rtl/gpio_regfile_responder.sv
// rtl/gpio_regfile_responder.sv - GPIO command-channel responder: handshake FSM and response formatting
module gpio_regfile_responder
  import gpio_rf_pkg::*;
#(
  parameter int          NB_GPIOS = 32,
  parameter int          N_WREG   = 8,
  parameter int          N_RREG   = 8,
  parameter int          NB_ADDR  = 8,
  parameter logic [15:0] VERSION  = DEFAULT_VERSION
) (
  input  logic                 clk,
  input  logic                 in_reset,
  input  logic [NB_GPIOS-1:0]  i_gpo,
  output logic [NB_GPIOS-1:0]  o_gpi,
  output logic [N_WREG*32-1:0] o_wregs,
  input  logic [N_RREG*32-1:0] i_rregs,
  output logic                 o_wr_pulse,
  output logic [NB_ADDR-1:0]   o_wr_addr,
  output logic                 o_soft_reset
);

  state_e             state;
  logic [7:0]         gpo_cmd_q;
  logic               gpo_req_q;
  logic [15:0]        gpo_pay_q;
  logic [7:0]         cmd_q;
  logic [15:0]        payload_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [15:0]        wr_lo;
  logic [15:0]        rd_hold_hi;
  logic [7:0]         gpi_cmd;
  logic               gpi_ack;
  logic               gpi_err;
  logic [15:0]        gpi_rdata;

  logic               bank_we;
  logic               bank_clear;
  logic               bank_wr_ok;
  logic               bank_rd_ok;
  logic [31:0]        bank_rdata;
  logic [6:0]         unused_gpo_bits;

  assign unused_gpo_bits = i_gpo[22:16];

  // The bank acts on the single EXEC cycle of a write or soft-reset command
  assign bank_we    = (state == ST_EXEC) && (cmd_q == CMD_WR_HI);
  assign bank_clear = (state == ST_EXEC) && (cmd_q == CMD_SOFT_RST);

  assign o_gpi = NB_GPIOS'(pack_gpi(gpi_cmd, gpi_ack, gpi_err, gpi_rdata));

  gpio_rf_bank #(
    .N_WREG  (N_WREG),
    .N_RREG  (N_RREG),
    .NB_ADDR (NB_ADDR)
  ) u_bank (
    .clk    (clk),
    .resetn (in_reset),
    .clear  (bank_clear),
    .we     (bank_we),
    .addr   (addr_q),
    .wdata  ({payload_q, wr_lo}),
    .rregs  (i_rregs),
    .wregs  (o_wregs),
    .wr_ok  (bank_wr_ok),
    .rd_ok  (bank_rd_ok),
    .rdata  (bank_rdata)
  );

  // Register the command word once; the FSM only ever looks at this copy
  always_ff @(posedge clk) begin
    if (!in_reset) begin
      gpo_cmd_q <= '0;
      gpo_req_q <= 1'b0;
      gpo_pay_q <= '0;
    end else begin
      gpo_cmd_q <= i_gpo[GPO_CMD_LSB +: 8];
      gpo_req_q <= i_gpo[GPO_REQ_BIT];
      gpo_pay_q <= i_gpo[GPO_PAY_LSB +: 16];
    end
  end

  // Handshake FSM: latch on req, execute for one cycle, hold ack until req drops
  always_ff @(posedge clk) begin
    if (!in_reset) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      payload_q    <= '0;
      addr_q       <= '0;
      wr_lo        <= '0;
      rd_hold_hi   <= '0;
      gpi_cmd      <= '0;
      gpi_ack      <= 1'b0;
      gpi_err      <= 1'b0;
      gpi_rdata    <= '0;
      o_wr_pulse   <= 1'b0;
      o_wr_addr    <= '0;
      o_soft_reset <= 1'b0;
    end else begin
      o_wr_pulse   <= 1'b0;
      o_soft_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gpo_req_q) begin
            cmd_q        <= gpo_cmd_q;
            payload_q    <= gpo_pay_q;
            // Raised on entry so the strobe covers exactly the EXEC cycle
            o_soft_reset <= (gpo_cmd_q == CMD_SOFT_RST);
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          gpi_cmd <= cmd_q;
          gpi_err <= 1'b0;
          gpi_ack <= 1'b1;
          state   <= ST_ACK;
          case (cmd_q)
            CMD_NOP: begin
            end
            CMD_SOFT_RST: begin
              addr_q     <= '0;
              wr_lo      <= '0;
              rd_hold_hi <= '0;
            end
            CMD_SET_ADDR: addr_q <= payload_q[NB_ADDR-1:0];
            CMD_WR_LO:    wr_lo  <= payload_q;
            CMD_WR_HI: begin
              if (bank_wr_ok) begin
                o_wr_pulse <= 1'b1;
                o_wr_addr  <= addr_q;
              end else begin
                gpi_err <= 1'b1;
              end
            end
            CMD_RD_LO: begin
              // Only the upper half must be held; the lower half is returned now
              rd_hold_hi <= bank_rdata[31:16];
              gpi_rdata  <= bank_rdata[15:0];
              gpi_err    <= !bank_rd_ok;
            end
            CMD_RD_HI:   gpi_rdata <= rd_hold_hi;
            CMD_VERSION: gpi_rdata <= VERSION;
            default:     gpi_err   <= 1'b1;
          endcase
        end
        ST_ACK: begin
          if (!gpo_req_q) begin
            gpi_ack <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpio_regfile_responder.md
Name: gpio_regfile_responder

Overview:
- Fabric-side responder for the MicroBlaze GPIO command channel.
- Decodes 32-bit command words written by firmware on the GPIO output bus and maintains a bank of 32-bit write registers driven into the fabric.
- Returns read-back data, status and error on the GPIO input bus, using a 4-phase req/ack handshake.
- Sits in the clockdsp domain between the processor GPIO ports and the application datapath.

Parameters:
- NB_GPIOS, 32, GPIO bus width; only 32 is legal.
- N_WREG, 8, number of writable 32-bit registers (addresses 0..N_WREG-1).
- N_RREG, 8, number of read-only 32-bit registers from fabric (addresses N_WREG..N_WREG+N_RREG-1).
- NB_ADDR, 8, register address width.
- VERSION, 16'h0100, constant returned by the VERSION command.

Ports:
- clk  in  1  application clock (clockdsp).
- in_reset  in  1  reset, synchronous, active-low.
- i_gpo  in  NB_GPIOS  command word from the processor.
- o_gpi  out  NB_GPIOS  response word to the processor.
- o_wregs  out  N_WREG*32  flattened write registers; register k occupies [32k+31:32k].
- i_rregs  in  N_RREG*32  flattened read-only registers from fabric.
- o_wr_pulse  out  1  one-cycle strobe on every successful register commit.
- o_wr_addr  out  NB_ADDR  address of the last commit.
- o_soft_reset  out  1  one-cycle soft reset pulse to the application.

Behaviour:
- i_gpo fields: [31:24] cmd, [23] req, [22:16] ignored, [15:0] payload.
- o_gpi fields: [31:24] echoed cmd, [23] ack, [22] err, [21:16] zero, [15:0] rdata.
- Reset (in_reset=0 at a clk edge): all outputs 0, FSM IDLE, addr/wr_lo/rd_hold 0. Reset applies mid-handshake and overrides all activity.
- i_gpo is registered once (gpo_q); the FSM uses gpo_q only.
- FSM states IDLE -> EXEC -> ACK -> IDLE.
  - IDLE: when gpo_q.req=1, latch cmd and payload, go to EXEC.
  - EXEC: runs one cycle. Perform the action; update o_gpi cmd/err/rdata (rdata unchanged if the command does not produce data). Go to ACK.
  - ACK: o_gpi.ack=1. Stay until gpo_q.req=0, then ack=0 and go to IDLE. cmd/payload changes while in ACK are ignored.
- Latency:
  - req rising at i_gpo in cycle 0 -> ack=1 visible after edge 3.
  - req falling -> ack=0 after edge 2.
  - A req held high executes exactly once.
- err is rewritten on every command: 0 on success, 1 on failure.
- Commands:
  - 0x00 NOP: no effect.
  - 0x01 SOFT_RST: o_soft_reset=1 for the EXEC cycle; clears o_wregs, addr, wr_lo, rd_hold; the handshake still completes.
  - 0x02 SET_ADDR: addr <= payload[NB_ADDR-1:0]; never errors.
  - 0x03 WR_LO: wr_lo <= payload.
  - 0x04 WR_HI: if addr<N_WREG, reg[addr] <= {payload, wr_lo}, o_wr_pulse=1 for one cycle, o_wr_addr<=addr. Otherwise err=1, no write, no pulse.
  - 0x05 RD_LO: snapshot rd_hold <= word at addr (write reg, read-only reg, or 0 if out of range with err=1); rdata <= rd_hold[15:0] of the new snapshot.
  - 0x06 RD_HI: rdata <= rd_hold[31:16]; no new snapshot, so the 32-bit read is coherent.
  - 0x07 VERSION: rdata <= VERSION.
  - Any other code: err=1, no side effect.
- o_wregs update on the edge ending EXEC. Write regs read back the current value, including a commit from the preceding command.
- wr_lo persists across commands until overwritten or cleared.

Decomposition:
- Package gpio_rf_pkg holds:
  - command code constants;
  - o_gpi/i_gpo field bit positions;
  - FSM state encoding;
  - default VERSION.
- One sub-module, gpio_rf_bank, holds write-register storage, write decode, address range check, and the combinational read mux over write and read-only registers.
- The FSM, handshake and response formatting stay in the top module.

Test Plan:
- Reset: hold in_reset=0 for 4 cycles with i_gpo=0x0580_0000 -> all outputs 0. Release -> ack=1 exactly 3 edges later, echoed cmd 0x05.
- Write: SET_ADDR 3, WR_LO 0xBEEF, WR_HI 0xDEAD -> o_wregs[3]=0xDEADBEEF, o_wr_pulse high for one cycle with o_wr_addr=3, err=0; other registers unchanged.
- Coherent read: i_rregs[1]=0x12345678, SET_ADDR 9, RD_LO -> rdata 0x5678. Change i_rregs[1] to 0xAAAA0000, then RD_HI -> rdata 0x1234.
- Errors:
  - SET_ADDR 10, WR_HI -> err=1, no pulse.
  - SET_ADDR 20, RD_LO -> rdata 0, err=1.
  - cmd 0x3F -> err=1.
  - Next NOP -> err=0.
- Handshake: hold req=1 for 50 cycles while toggling payload -> one execution only; deassert -> ack=0 after 2 edges. Reassert in the same cycle ack falls -> new command accepted.
- Soft/mid reset:
  - SOFT_RST after writes -> o_soft_reset one cycle, o_wregs all 0, ack completes.
  - in_reset=0 during ACK -> ack=0 next edge, FSM IDLE.
